// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter: load/clear/enable commands in,
// registered count and status flags out.
interface down_counter_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] iLoadValue;
  logic             enable;
  logic             iAutoReload;
  logic [WIDTH-1:0] oResult;
  logic             oZero;
  logic             oDone;
  logic             oBusy;

  modport master (
    output clear, load, iLoadValue, enable, iAutoReload,
    input  oResult, oZero, oDone, oBusy
  );

  modport slave (
    input  clear, load, iLoadValue, enable, iAutoReload,
    output oResult, oZero, oDone, oBusy
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with one-shot or periodic reload, a registered
// terminal-count pulse and an IDLE/RUN state machine.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  down_counter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             done_reg;
  logic             done_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= ZERO;
      reload_reg <= ZERO;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      done_reg   <= done_next;
    end
  end

  // Priority is clear, then load, then counting; only the counting branch
  // can raise done, so a colliding load/clear suppresses the pulse.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    done_next   = 1'b0;

    if (bus.clear) begin
      state_next = IDLE;
      count_next = ZERO;
    end else if (bus.load) begin
      count_next  = bus.iLoadValue;
      reload_next = bus.iLoadValue;
      state_next  = (bus.iLoadValue != ZERO) ? RUN : IDLE;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.enable) begin
            if (count_reg == ONE) begin
              done_next = 1'b1;
              if (bus.iAutoReload) begin
                count_next = reload_reg;
              end else begin
                count_next = ZERO;
                state_next = IDLE;
              end
            end else if (count_reg == ZERO) begin
              // Unreachable in normal use; never let RUN wrap below zero.
              state_next = IDLE;
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.oResult = count_reg;
  assign bus.oZero   = (count_reg == ZERO);
  assign bus.oDone   = done_reg;
  assign bus.oBusy   = (state_reg == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table, hand-written corner
// sequences and a randomized run against a cycle-level reference model.
module tb_down_counter;

  localparam int WIDTH = 8;

  logic clock;
  logic reset;

  down_counter_if #(.WIDTH(WIDTH)) dc_if ();

  down_counter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dc_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state, described by the counter's behavioural rules.
  int m_cnt    = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_done   = 0;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] val;
    logic       en;
    logic       ar;
    int         exp_res;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic ld, int val, logic en, logic ar,
                              int exp_res, logic exp_done, logic exp_busy);
    vec_t v;
    v.clr = clr; v.ld = ld; v.val = 8'(val); v.en = en; v.ar = ar;
    v.exp_res = exp_res; v.exp_done = exp_done; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit clr, input bit ld, input int val,
                            input bit en, input bit ar);
    m_done = 0;
    if (clr) begin
      m_cnt = 0;
      m_run = 0;
    end else if (ld) begin
      m_cnt    = val;
      m_reload = val;
      m_run    = (val != 0);
    end else if (m_run && en) begin
      if (m_cnt == 1) begin
        m_done = 1;
        if (ar) m_cnt = m_reload;
        else begin
          m_cnt = 0;
          m_run = 0;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // Drive one set of inputs, take one clock edge, advance the model and
  // leave the caller 1 ns after the edge for sampling.
  task automatic step(input logic clr, input logic ld, input logic [7:0] val,
                      input logic en, input logic ar);
    dc_if.clear       = clr;
    dc_if.load        = ld;
    dc_if.iLoadValue  = val;
    dc_if.enable      = en;
    dc_if.iAutoReload = ar;
    @(posedge clock);
    #1;
    model_edge(clr, ld, int'(val), en, ar);
  endtask

  task automatic check_model(input string tag);
    check({tag, " result"}, int'(dc_if.oResult), m_cnt);
    check({tag, " done"},   int'(dc_if.oDone),   int'(m_done));
    check({tag, " busy"},   int'(dc_if.oBusy),   int'(m_run));
    check({tag, " zero"},   int'(dc_if.oZero),   int'(m_cnt == 0));
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic async_reset_pulse();
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("async result", int'(dc_if.oResult), 0);
    check("async zero",   int'(dc_if.oZero),   1);
    check("async busy",   int'(dc_if.oBusy),   0);
    check("async done",   int'(dc_if.oDone),   0);
    #1 reset = 1'b0;
  endtask

  initial begin
    int exp;
    int enabled_edges;

    reset = 1'b1;
    dc_if.clear = 1'b0;
    dc_if.load = 1'b0;
    dc_if.iLoadValue = '0;
    dc_if.enable = 1'b0;
    dc_if.iAutoReload = 1'b0;
    #2;
    check("reset result", int'(dc_if.oResult), 0);
    check("reset zero",   int'(dc_if.oZero),   1);
    check("reset busy",   int'(dc_if.oBusy),   0);
    check("reset done",   int'(dc_if.oDone),   0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // Vector table: one-shot, periodic, reload 1, load 0, collisions.
    vecs.push_back(mk(0, 1,   5, 0, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   3, 0, 1, 3, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 3, 1, 1));
    vecs.push_back(mk(0, 0,   0, 0, 1, 3, 0, 1));
    vecs.push_back(mk(0, 1,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0,   0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1,   2, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1,   7, 1, 0, 7, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 6, 0, 1));
    vecs.push_back(mk(0, 1,   2, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ar);
      check($sformatf("vec%0d result", i), int'(dc_if.oResult), vecs[i].exp_res);
      check($sformatf("vec%0d done", i),   int'(dc_if.oDone),   int'(vecs[i].exp_done));
      check($sformatf("vec%0d busy", i),   int'(dc_if.oBusy),   int'(vecs[i].exp_busy));
      check($sformatf("vec%0d zero", i),   int'(dc_if.oZero),   int'(vecs[i].exp_res == 0));
    end

    // Enable gaps: only enabled edges decrement.
    step(0, 1, 8'd4, 0, 0);
    check("gap load", int'(dc_if.oResult), 4);
    enabled_edges = 0;
    for (int i = 0; i < 10; i++) begin
      logic en;
      en = (i % 2 == 0);
      step(0, 0, 8'd0, en, 0);
      if (en && enabled_edges < 4) enabled_edges++;
      exp = 4 - enabled_edges;
      check($sformatf("gap%0d result", i), int'(dc_if.oResult), exp);
      check($sformatf("gap%0d done", i), int'(dc_if.oDone),
            int'(en && i == 6));
    end

    // Full-range count: 255 enabled edges, no wrap.
    step(0, 1, 8'd255, 0, 0);
    check("max load", int'(dc_if.oResult), 255);
    for (int k = 1; k <= 255; k++) begin
      step(0, 0, 8'd0, 1, 0);
      check($sformatf("max%0d result", k), int'(dc_if.oResult), 255 - k);
      check($sformatf("max%0d done", k), int'(dc_if.oDone), int'(k == 255));
    end
    step(0, 0, 8'd0, 1, 0);
    check("max after result", int'(dc_if.oResult), 0);
    check("max after done",   int'(dc_if.oDone),   0);

    // Asynchronous reset mid-run, then enable alone must not move the count.
    step(0, 1, 8'd200, 0, 0);
    repeat (50) step(0, 0, 8'd0, 1, 0);
    check("pre-reset result", int'(dc_if.oResult), 150);
    async_reset_pulse();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'd0, 1, 1);
      check($sformatf("post-reset%0d result", i), int'(dc_if.oResult), 0);
      check($sformatf("post-reset%0d busy", i),   int'(dc_if.oBusy),   0);
      check($sformatf("post-reset%0d done", i),   int'(dc_if.oDone),   0);
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic       clr, ld, en, ar;
      logic [7:0] val;
      clr = ($urandom_range(0, 99) < 3);
      ld  = ($urandom_range(0, 99) < 8);
      val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if ($urandom_range(0, 1) == 1) val = 8'($urandom_range(0, 12));
      en  = ($urandom_range(0, 99) < 75);
      ar  = 1'($urandom_range(0, 1));
      step(clr, ld, val, en, ar);
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of count, load value and reload register.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: clear  input  1  synchronous abort to IDLE with count 0.
REQ-005 SHALL have port: load  input  1  synchronous load of iLoadValue.
REQ-006 SHALL have port: iLoadValue  input  WIDTH  start/period value captured on load.
REQ-007 SHALL have port: enable  input  1  count-down qualifier in RUN.
REQ-008 SHALL have port: iAutoReload  input  1  1 = periodic mode, 0 = one-shot; sampled at each terminal count.
REQ-009 SHALL have port: oResult  output  WIDTH  current count, registered.
REQ-010 SHALL have port: oZero  output  1  high whenever oResult == 0.
REQ-011 SHALL have port: oDone  output  1  registered one-cycle pulse on terminal count.
REQ-012 SHALL have port: oBusy  output  1  high while state is RUN.

Function
REQ-013 SHALL implement two states: IDLE, RUN; oBusy = (state == RUN).
REQ-014 SHALL apply input priority per edge: clear > load > enable.
REQ-015 clear SHALL: oResult <= 0, state <= IDLE, oDone <= 0; reload register unchanged.
REQ-016 load with iLoadValue != 0 SHALL: oResult <= iLoadValue, reload register <= iLoadValue, state <= RUN, from either state.
REQ-017 load with iLoadValue == 0 SHALL: oResult <= 0, reload register <= 0, state <= IDLE, no oDone.
REQ-018 In RUN with enable = 1 and oResult > 1: oResult <= oResult - 1.
REQ-019 In RUN with enable = 1 and oResult == 1 (terminal count): oDone <= 1 for exactly the next cycle.
REQ-020 At terminal count with iAutoReload = 0: oResult <= 0, state <= IDLE.
REQ-021 At terminal count with iAutoReload = 1: oResult <= reload register, state stays RUN; period = reload value enabled cycles.
REQ-022 In RUN with enable = 0: oResult, state hold; oDone <= 0.
REQ-023 In IDLE without load/clear: oResult holds; enable ignored; no decrement below 0 (no wrap to all-ones).
REQ-024 oDone SHALL be 0 on every cycle not immediately following a terminal-count edge.
REQ-025 load or clear coincident with terminal count SHALL win; oDone SHALL NOT pulse for that edge.
REQ-026 Reload value 1 with iAutoReload = 1 SHALL yield oDone high every enabled cycle, oResult constant 1.
REQ-027 Arithmetic SHALL be unsigned WIDTH-bit; max load 2^WIDTH-1 counts down fully without overflow.

Reset
REQ-028 reset high SHALL immediately (asynchronously) force oResult = 0, reload register = 0, state = IDLE, oDone = 0, oBusy = 0, oZero = 1.
REQ-029 reset asserted mid-RUN SHALL abort the count with no oDone pulse; after deassertion block stays IDLE until load.
REQ-030 reset SHALL have priority over all other inputs.

Verification
REQ-031 One-shot: load 5, enable=1, iAutoReload=0 -> oResult 5,4,3,2,1,0; oDone high 1 cycle with oResult=0; oBusy falls same edge; holds 0.
REQ-032 Periodic: load 3, iAutoReload=1, enable=1 for 9 cycles -> oResult 3,2,1,3,2,1,3,2,1; oDone pulses 3 times, each when oResult returns to 3.
REQ-033 Enable gaps: load 4, enable toggled 1,0,1,0,... -> oResult decrements only on enabled edges; reaches 0 after 4 enabled edges.
REQ-034 Collision: at oResult=1 with enable=1 assert load 7 -> oResult=7, no oDone; repeat with clear -> oResult=0, IDLE, no oDone.
REQ-035 Async reset: load 200 (WIDTH=8), count to 150, pulse reset between clock edges -> outputs 0/IDLE before next edge, oZero=1; enable alone afterwards leaves oResult 0.
REQ-036 Boundaries: load 0 -> IDLE, oZero=1, no oDone; load 255 -> counts to 0 in 255 enabled cycles, never wraps.
